// File: rtl/conv1d_mac_lanes.sv
// rtl/conv1d_mac_lanes.sv - conv1d CFU datapath: int8 ring/filter buffers, LANES MACs per beat, requant handshake.
// Optional buffer readback (cmds 11/12) is built when CONV1D_READBACK_EN is defined.
module conv1d_mac_lanes #(
    parameter int KERNEL_LENGTH      = 8,
    parameter int MAX_INPUT_CHANNELS = 128,
    parameter int LANES              = 8,
    parameter int DATA_W             = 8,
    parameter int ACC_W              = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [6:0]       cmd,
    input  logic [ACC_W-1:0] inp0,
    input  logic [ACC_W-1:0] inp1,
    output logic [ACC_W-1:0] ret,
    output logic             busy,
    output logic [ACC_W-1:0] quant_acc,
    output logic             quant_start,
    input  logic             quant_done,
    input  logic [ACC_W-1:0] quant_ret
);
    localparam int BUF = KERNEL_LENGTH * MAX_INPUT_CHANNELS;
    localparam int AW  = $clog2(BUF);
    localparam int CW  = AW + 1;
    localparam int LW  = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, MAC, QSTART, QWAIT} state_t;

    logic [DATA_W-1:0] in_buf   [BUF];
    logic [DATA_W-1:0] filt_buf [BUF];

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] qres;
    logic [ACC_W-1:0] input_offset;
    logic [ACC_W-1:0] input_depth;
    logic [ACC_W-1:0] start_x;
    logic [CW-1:0]    cur;
    logic [CW-1:0]    a;
    logic [CW-1:0]    k;
    logic             done;
    logic             err;
    logic             drop;

    logic [AW-1:0]    waddr;
    logic [CW-1:0]    depth_n;
    logic [CW-1:0]    cur_cfg;
    logic [CW-1:0]    a_start;
    logic             cfg_ok;
    logic             write_cmd;
    logic             unused_bits;

    assign quant_acc   = acc;
    assign waddr       = {inp0[AW-1:2], 2'b00};
    assign unused_bits = ^{inp0[ACC_W-1:AW], inp0[1:0]};

    assign depth_n = input_depth[CW-1:0];
    assign cur_cfg = CW'(KERNEL_LENGTH) * depth_n;
    assign a_start = start_x[CW-1:0] * depth_n;
    assign cfg_ok  = (input_depth != '0)
                  && (input_depth <= ACC_W'(MAX_INPUT_CHANNELS))
                  && (cur_cfg[LW-1:0] == '0)
                  && (start_x < ACC_W'(KERNEL_LENGTH));

    assign write_cmd = (cmd == 7'd1) || (cmd == 7'd2) || (cmd == 7'd3)
                    || (cmd == 7'd5) || (cmd == 7'd8);

    // One beat: LANES taps, input address wraps per lane around the cur-byte ring.
    logic [CW-1:0]    lane_a;
    logic [CW-1:0]    lane_k;
    logic [ACC_W-1:0] xv;
    logic [ACC_W-1:0] wv;
    logic [ACC_W-1:0] beat_sum;
    logic [CW-1:0]    a_next;

    always_comb begin
        beat_sum = '0;
        lane_a   = '0;
        lane_k   = '0;
        xv       = '0;
        wv       = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_a = a + CW'(i);
            if (lane_a >= cur)
                lane_a = lane_a - cur;
            lane_k = k + CW'(i);
            xv = {{(ACC_W-DATA_W){in_buf[lane_a[AW-1:0]][DATA_W-1]}}, in_buf[lane_a[AW-1:0]]}
               + input_offset;
            wv = {{(ACC_W-DATA_W){filt_buf[lane_k[AW-1:0]][DATA_W-1]}}, filt_buf[lane_k[AW-1:0]]};
            beat_sum = beat_sum + wv * xv;
        end
        a_next = a + CW'(LANES);
        if (a_next >= cur)
            a_next = a_next - cur;
    end

    always_ff @(posedge clk) begin
        if (en && !busy && !reset) begin
            if (cmd == 7'd1) begin
                for (int j = 0; j < 4; j++)
                    in_buf[waddr + AW'(j)] <= inp1[j*DATA_W +: DATA_W];
            end else if (cmd == 7'd2) begin
                for (int j = 0; j < 4; j++)
                    filt_buf[waddr + AW'(j)] <= inp1[j*DATA_W +: DATA_W];
            end
        end
    end

`ifdef CONV1D_READBACK_EN
    logic [ACC_W-1:0] rb_in;
    logic [ACC_W-1:0] rb_filt;

    always_comb begin
        rb_in   = '0;
        rb_filt = '0;
        for (int j = 0; j < 4; j++) begin
            rb_in[j*DATA_W +: DATA_W]   = in_buf[waddr + AW'(j)];
            rb_filt[j*DATA_W +: DATA_W] = filt_buf[waddr + AW'(j)];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ret          <= '0;
            busy         <= 1'b0;
            quant_start  <= 1'b0;
            acc          <= '0;
            qres         <= '0;
            done         <= 1'b1;
            err          <= 1'b0;
            drop         <= 1'b0;
            input_offset <= '0;
            input_depth  <= '0;
            start_x      <= '0;
            cur          <= '0;
            a            <= '0;
            k            <= '0;
        end else begin
            quant_start <= 1'b0;

            if (en) begin
                ret <= '0;
                if (write_cmd && busy)
                    drop <= 1'b1;
                case (cmd)
                    7'd0: begin
                        ret  <= ACC_W'(BUF);
                        err  <= 1'b0;
                        drop <= 1'b0;
                    end
                    7'd3:  if (!busy) input_offset <= inp1;
                    7'd5:  if (!busy) input_depth  <= inp1;
                    7'd8:  if (!busy) start_x      <= inp1;
                    7'd6: begin
                        if (state == IDLE) begin
                            if (cfg_ok) begin
                                acc   <= '0;
                                k     <= '0;
                                a     <= a_start;
                                cur   <= cur_cfg;
                                done  <= 1'b0;
                                busy  <= 1'b1;
                                state <= MAC;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    7'd7:  ret <= qres;
                    7'd9:  ret <= ACC_W'({drop, err, done});
                    7'd10: ret <= acc;
`ifdef CONV1D_READBACK_EN
                    7'd11: ret <= rb_in;
                    7'd12: ret <= rb_filt;
`endif
                    default: ;
                endcase
            end

            case (state)
                MAC: begin
                    acc <= acc + beat_sum;
                    k   <= k + CW'(LANES);
                    a   <= a_next;
                    if (k + CW'(LANES) == cur) begin
                        state       <= QSTART;
                        quant_start <= 1'b1;
                    end
                end
                QSTART: state <= QWAIT;
                QWAIT: begin
                    if (quant_done) begin
                        qres  <= quant_ret;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv1d_mac_lanes.sv
// tb/tb_conv1d_mac_lanes.sv - scoreboard bench for conv1d_mac_lanes with an echoing requant responder.
module tb_conv1d_mac_lanes;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [6:0]  cmd;
    logic [31:0] inp0;
    logic [31:0] inp1;
    logic [31:0] ret;
    logic        busy;
    logic [31:0] quant_acc;
    logic        quant_start;
    logic        quant_done;
    logic [31:0] quant_ret;

    always #5 clk = ~clk;

    conv1d_mac_lanes dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cmd         (cmd),
        .inp0        (inp0),
        .inp1        (inp1),
        .ret         (ret),
        .busy        (busy),
        .quant_acc   (quant_acc),
        .quant_start (quant_start),
        .quant_done  (quant_done),
        .quant_ret   (quant_ret)
    );

    int          checks = 0;
    int          errors = 0;
    int          qs_cycles = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        chk_now = 1'b0;
    logic        chk_d = 1'b0;

    always @(posedge clk) chk_d <= chk_now;

    // Monitor: ret is valid the cycle after a read command.
    always @(negedge clk) begin
        if (chk_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: ret=%0h with nothing expected", ret);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (ret !== e) begin
                    errors++;
                    $display("FAIL %s: ret=%0h expected %0h", n, ret, e);
                end
            end
        end
    end

    always @(negedge clk) if (quant_start === 1'b1) qs_cycles++;

    // Requant stand-in: echoes the raw accumulator two cycles after the pulse.
    initial begin
        quant_done = 1'b0;
        quant_ret  = '0;
        forever begin
            @(negedge clk);
            if (quant_start === 1'b1) begin
                repeat (2) @(negedge clk);
                quant_ret  = quant_acc;
                quant_done = 1'b1;
                @(negedge clk);
                quant_done = 1'b0;
            end
        end
    end

    task automatic send(input logic [6:0] c, input logic [31:0] a0, input logic [31:0] a1,
                        input bit chk, input logic [31:0] e, input string n);
        @(negedge clk);
        en = 1'b1; cmd = c; inp0 = a0; inp1 = a1; chk_now = chk;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(n);
        end
        @(posedge clk);
        #1;
        en = 1'b0; chk_now = 1'b0;
    endtask

    task automatic wr(input logic [6:0] c, input logic [31:0] a0, input logic [31:0] a1);
        send(c, a0, a1, 1'b0, 32'h0, "");
    endtask

    task automatic rd(input logic [6:0] c, input logic [31:0] a0, input logic [31:0] e, input string n);
        send(c, a0, 32'h0, 1'b1, e, n);
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, e);
        end
    endtask

    task automatic wait_idle(input string n, input int exp_cycles);
        int cnt = 0;
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            cnt++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: busy never fell, expected %0d busy cycles", n, exp_cycles);
        end else begin
            check(n, cnt, exp_cycles);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    int qs0;

    initial begin
        reset = 1'b1; en = 1'b0; cmd = '0; inp0 = '0; inp1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ret", ret, 32'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_quant_start", quant_start, 1'b0);

        // 1: buffer size and status after reset, unknown command
        rd(7'd0, 0, 32'd1024, "cmd0_bufsize");
        rd(7'd9, 0, 32'd1, "status_after_reset");
        rd(7'd15, 0, 32'd0, "unknown_cmd");
        rd(7'd10, 0, 32'd0, "acc_after_reset");

        // 2: single beat, in=1..8, filt=1 -> 36
        wr(7'd1, 0, 32'h04030201);
        wr(7'd1, 4, 32'h08070605);
        wr(7'd2, 0, 32'h01010101);
        wr(7'd2, 4, 32'h01010101);
        wr(7'd5, 0, 1);
        wr(7'd8, 0, 0);
        wr(7'd3, 0, 0);
        qs0 = qs_cycles;
        wr(7'd6, 0, 0);
        check("busy_after_start", busy, 1'b1);
        wait_idle("busy_cycles_depth1", 4);
        check("quant_start_once", qs_cycles - qs0, 1);
        rd(7'd10, 0, 32'd36, "acc_depth1");
        rd(7'd7, 0, 32'd36, "qret_depth1");
        rd(7'd9, 0, 32'd1, "status_depth1");

        // 3: ring wrap, depth=2, start_x=3 -> a starts at 6
        for (int w = 0; w < 4; w++) begin
            wr(7'd1, 4*w, 32'h80808080);
            wr(7'd2, 4*w, 32'h02020202);
        end
        wr(7'd5, 0, 2);
        wr(7'd8, 0, 3);
        wr(7'd3, 0, 128);
        wr(7'd6, 0, 0);
        wait_idle("busy_cycles_depth2", 5);
        rd(7'd10, 0, 32'd0, "acc_offset128");
        rd(7'd7, 0, 32'd0, "qret_offset128");
        wr(7'd3, 0, 0);
        wr(7'd6, 0, 0);
        wait_idle("busy_cycles_depth2b", 5);
        rd(7'd10, 0, 32'hFFFFF000, "acc_offset0");
        rd(7'd7, 0, 32'hFFFFF000, "qret_offset0");

        // 4: invalid configurations
        qs0 = qs_cycles;
        wr(7'd5, 0, 0);
        wr(7'd6, 0, 0);
        check("busy_invalid_depth0", busy, 1'b0);
        rd(7'd9, 0, 32'd3, "status_depth0");
        rd(7'd0, 0, 32'd1024, "clear_err0");
        wr(7'd5, 0, 129);
        wr(7'd6, 0, 0);
        rd(7'd9, 0, 32'd3, "status_depth129");
        rd(7'd0, 0, 32'd1024, "clear_err1");
        wr(7'd5, 0, 1);
        wr(7'd8, 0, 8);
        wr(7'd6, 0, 0);
        rd(7'd9, 0, 32'd3, "status_startx8");
        rd(7'd0, 0, 32'd1024, "clear_err2");
        rd(7'd9, 0, 32'd1, "status_cleared");
        check("no_quant_start_invalid", qs_cycles - qs0, 0);

        // 5: writes while busy are dropped
        for (int w = 0; w < 256; w++) begin
            wr(7'd1, 4*w, 32'h01010101);
            wr(7'd2, 4*w, 32'h01010101);
        end
        wr(7'd5, 0, 128);
        wr(7'd8, 0, 0);
        wr(7'd3, 0, 0);
        wr(7'd6, 0, 0);
        wr(7'd1, 0, 32'h7F7F7F7F);
        wr(7'd5, 0, 1);
        rd(7'd9, 0, 32'd4, "status_busy_drop");
        wait_idle("busy_cycles_depth128", 128);
        rd(7'd10, 0, 32'd1024, "acc_depth128");
        rd(7'd9, 0, 32'd5, "status_drop_done");
        rd(7'd0, 0, 32'd1024, "clear_drop");
        rd(7'd9, 0, 32'd1, "status_drop_cleared");
        wr(7'd6, 0, 0);
        wait_idle("busy_cycles_rerun", 131);
        rd(7'd10, 0, 32'd1024, "acc_rerun_unchanged");
`ifdef CONV1D_READBACK_EN
        rd(7'd11, 0, 32'h01010101, "readback_input");
        rd(7'd12, 4, 32'h01010101, "readback_filter");
`else
        rd(7'd11, 0, 32'h0, "readback_disabled");
`endif

        // 6: reset mid-MAC
        wr(7'd6, 0, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("busy_after_abort", busy, 1'b0);
        rd(7'd9, 0, 32'd1, "status_after_abort");
        rd(7'd10, 0, 32'd0, "acc_after_abort");
        qs0 = qs_cycles;
        wr(7'd5, 0, 1);
        wr(7'd6, 0, 0);
        wait_idle("busy_cycles_after_abort", 4);
        rd(7'd10, 0, 32'd8, "acc_after_abort_run");
        check("quant_start_after_abort", qs_cycles - qs0, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
